// File: rtl/cpu_ex_seq.sv
// cpu_ex_seq: multi-cycle control sequencer for the cpu_ex datapath.
// Steps each instruction through FETCH -> DECODE -> EXEC -> WB. It drives the
// register-file addresses, every datapath write-enable and the PC increment
// strobe, and counts retired instructions.
//
// Fetch handshake: imem_req is high in every FETCH cycle. The word is taken
// (we_ir pulses) in the cycle where imem_req && imem_ack. imem_ack outside
// FETCH is ignored. There is no timeout, so FETCH waits as long as it needs to.
//
// Only the state register and the retired counter are flops. Every other
// output decodes from the current state, ir and the handshake inputs. When
// n_rst is asserted, the state drops to IDLE at once, so all enables fall
// without waiting for a clock edge.
module cpu_ex_seq #(
  parameter int IW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          stop,
  input  logic          imem_ack,
  input  logic [IW-1:0] ir,
  output logic          imem_req,
  output logic          we_ir,
  output logic          we_sr,
  output logic          we_tr,
  output logic          we_dr,
  output logic          we_rf,
  output logic [2:0]    ra1,
  output logic [2:0]    ra2,
  output logic [2:0]    wa,
  output logic [2:0]    alu_op,
  output logic          pc_inc,
  output logic          halted,
  output logic          busy,
  output logic [CW-1:0] retired,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    op;
  logic [2:0]    rd;
  logic [2:0]    rs1;
  logic [2:0]    rs2;
  logic          unused_ir_bits;

  // Instruction field extraction.
  assign op  = ir[IW-1:IW-4];
  assign rd  = ir[IW-5:IW-7];
  assign rs1 = ir[IW-8:IW-10];
  assign rs2 = ir[IW-11:IW-13];
  assign unused_ir_bits = &{1'b0, ir[IW-14:0]};

  // Register-file addresses follow IR in every state.
  assign ra1 = rs1;
  assign ra2 = rs2;
  assign wa  = rd;

  assign state_dbg = state;

  // Next-state decode. A busy sequencer ignores start. Stop is only looked at
  // in WB, and it takes priority over start there.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = stop ? S_IDLE : S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register and saturating retired counter. The counter advances on
  // the WB exit edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WB && !(&retired))
        retired <= retired + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Output decode from the state. we_ir is Mealy on imem_ack, so IR is
  // written only in the cycle the word is valid.
  always_comb begin
    imem_req = 1'b0;
    we_ir    = 1'b0;
    we_sr    = 1'b0;
    we_tr    = 1'b0;
    we_dr    = 1'b0;
    we_rf    = 1'b0;
    pc_inc   = 1'b0;
    halted   = 1'b0;
    busy     = 1'b0;
    alu_op   = 3'd0;
    unique case (state)
      S_IDLE: ;
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        we_ir    = imem_ack;
      end
      S_DECODE: begin
        busy  = 1'b1;
        we_sr = (op != OP_HALT);
        we_tr = (op != OP_HALT);
      end
      S_EXEC: begin
        busy   = 1'b1;
        we_dr  = 1'b1;
        alu_op = op[2:0];
      end
      S_WB: begin
        busy   = 1'b1;
        we_rf  = (op != OP_NOP);
        pc_inc = 1'b1;
        alu_op = op[2:0];
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
